eth_tx_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter sharing the single TX AXI-stream input of the FIFO-backed 1G MAC among PORTS requesters.
- Sits in the logic clock domain, directly upstream of the MAC TX FIFO.
- Never interleaves frames.
- Terminates frames whose source stalls mid-frame as bad (tuser=1), so the frame FIFO drops them; the remainder of the stalled frame is then drained and discarded.

---
 rtl/eth_tx_frame_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : eth_tx_frame_arbiter
// Purpose  : frame-granular round-robin arbiter in front of the MAC TX FIFO,
//            aborting frames whose granted source stalls mid-frame.
// Revision : 1.0
// ============================================================================
module eth_tx_frame_arbiter #(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH/8,
   parameter int TIMEOUT    = 1024,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [PORTS*KEEP_WIDTH-1:0]   s_axis_tkeep,
   input  logic [PORTS-1:0]              s_axis_tvalid,
   output logic [PORTS-1:0]              s_axis_tready,
   input  logic [PORTS-1:0]              s_axis_tlast,
   input  logic [PORTS-1:0]              s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tuser,
   output logic                          grant_valid,
   output logic [$clog2(PORTS)-1:0]      grant_index,
   output logic                          frame_done,
   output logic [PORTS-1:0]              timeout_abort
);

   localparam int                   c_idx_width = $clog2(PORTS);
   localparam logic [CNT_WIDTH-1:0] c_timeout   = CNT_WIDTH'(TIMEOUT);
   localparam logic [c_idx_width-1:0] c_last_port = c_idx_width'(PORTS-1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS  = 2'd1,
      ST_ABORT = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [c_idx_width-1:0]   r_grant_index;
   logic [c_idx_width-1:0]   w_next_grant;
   logic [c_idx_width-1:0]   w_scan_idx;
   logic [CNT_WIDTH-1:0]     r_wd_cnt;
   logic                     r_frame_done;
   logic [PORTS-1:0]         r_timeout_abort;
   logic [PORTS-1:0]         w_grant_onehot;
   logic [DATA_WIDTH-1:0]    w_sel_data;
   logic [KEEP_WIDTH-1:0]    w_sel_keep;
   logic                     w_sel_valid;
   logic                     w_sel_last;
   logic                     w_sel_user;
   logic                     w_pass_last;
   logic                     w_timeout;

   // Granted-port mux
   always_comb begin
      w_sel_data     = '0;
      w_sel_keep     = '0;
      w_sel_valid    = 1'b0;
      w_sel_last     = 1'b0;
      w_sel_user     = 1'b0;
      w_grant_onehot = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (r_grant_index == c_idx_width'(i)) begin
            w_sel_data        = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            w_sel_keep        = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            w_sel_valid       = s_axis_tvalid[i];
            w_sel_last        = s_axis_tlast[i];
            w_sel_user        = s_axis_tuser[i];
            w_grant_onehot[i] = 1'b1;
         end
      end
   end

   // Scan from farthest to nearest so the closest requester after the
   // previous owner is the one left standing.
   always_comb begin
      w_next_grant = r_grant_index;
      w_scan_idx   = '0;
      for (int i = PORTS; i >= 1; i--) begin
         w_scan_idx = c_idx_width'((int'(r_grant_index) + i) % PORTS);
         if (s_axis_tvalid[w_scan_idx]) begin
            w_next_grant = w_scan_idx;
         end
      end
   end

   assign w_pass_last = (r_state == ST_PASS) && w_sel_valid && m_axis_tready && w_sel_last;
   assign w_timeout   = (TIMEOUT != 0) && (r_state == ST_PASS) && !w_sel_valid &&
                        (r_wd_cnt == c_timeout);

   always_comb begin
      w_next_state  = r_state;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      case (r_state)
         ST_IDLE: begin
            if (|s_axis_tvalid) begin
               w_next_state = ST_PASS;
            end
         end
         ST_PASS: begin
            m_axis_tdata  = w_sel_data;
            m_axis_tkeep  = w_sel_keep;
            m_axis_tvalid = w_sel_valid;
            m_axis_tlast  = w_sel_last;
            m_axis_tuser  = w_sel_user;
            s_axis_tready = w_grant_onehot & {PORTS{m_axis_tready}};
            if (w_pass_last) begin
               w_next_state = ST_IDLE;
            end else if (w_timeout) begin
               w_next_state = ST_ABORT;
            end
         end
         ST_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tkeep  = '1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            if (m_axis_tready) begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            s_axis_tready = w_grant_onehot;
            if (w_sel_valid && w_sel_last) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Watchdog saturates at the threshold; a beat in the threshold cycle clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant_index   <= c_last_port;
         r_wd_cnt        <= '0;
         r_frame_done    <= 1'b0;
         r_timeout_abort <= '0;
      end else begin
         r_frame_done    <= w_pass_last;
         r_timeout_abort <= w_timeout ? w_grant_onehot : '0;
         if ((r_state == ST_IDLE) && (|s_axis_tvalid)) begin
            r_grant_index <= w_next_grant;
         end
         if ((r_state != ST_PASS) || w_sel_valid) begin
            r_wd_cnt <= '0;
         end else if (r_wd_cnt != c_timeout) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end
      end
   end

   assign grant_valid   = (r_state != ST_IDLE);
   assign grant_index   = r_grant_index;
   assign frame_done    = r_frame_done;
   assign timeout_abort = r_timeout_abort;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_frame_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_eth_tx_frame_arbiter
// Purpose  : randomized frame traffic with a frame-level reference model and
//            a scoreboard monitor; ends with a mid-frame reset scenario.
// Revision : 1.0
// ============================================================================
module tb_eth_tx_frame_arbiter;

   localparam int PORTS   = 4;
   localparam int DW      = 8;
   localparam int KW      = 1;
   localparam int TIMEOUT = 8;
   localparam int CW      = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [PORTS*DW-1:0] s_axis_tdata;
   logic [PORTS*KW-1:0] s_axis_tkeep;
   logic [PORTS-1:0]    s_axis_tvalid;
   logic [PORTS-1:0]    s_axis_tready;
   logic [PORTS-1:0]    s_axis_tlast;
   logic [PORTS-1:0]    s_axis_tuser;
   logic [DW-1:0]       m_axis_tdata;
   logic [KW-1:0]       m_axis_tkeep;
   logic                m_axis_tvalid;
   logic                m_axis_tready;
   logic                m_axis_tlast;
   logic                m_axis_tuser;
   logic                grant_valid;
   logic [1:0]          grant_index;
   logic                frame_done;
   logic [PORTS-1:0]    timeout_abort;

   logic [DW-1:0] p_data  [PORTS];
   logic          p_keep  [PORTS];
   logic          p_valid [PORTS];
   logic          p_last  [PORTS];
   logic          p_user  [PORTS];

   always_comb begin
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tvalid = '0;
      s_axis_tlast  = '0;
      s_axis_tuser  = '0;
      for (int i = 0; i < PORTS; i++) begin
         s_axis_tdata[i*DW +: DW] = p_data[i];
         s_axis_tkeep[i]          = p_keep[i];
         s_axis_tvalid[i]         = p_valid[i];
         s_axis_tlast[i]          = p_last[i];
         s_axis_tuser[i]          = p_user[i];
      end
   end

   eth_tx_frame_arbiter #(
      .PORTS(PORTS), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .grant_valid(grant_valid), .grant_index(grant_index),
      .frame_done(frame_done), .timeout_abort(timeout_abort)
   );

   // Scoreboard: expected output beats {user,last,keep,data} and per-frame abort flag
   logic [10:0] exp_q [PORTS][$];
   bit          ab_q  [PORTS][$];

   int  checks = 0;
   int  fails  = 0;
   bit  stop_drv = 1'b0;
   int  drv_done = 0;
   bit  mon_en = 1'b1;
   bit  force_ready = 1'b0;

   // Frame-level reference state
   bit  mb_busy = 1'b0;
   bit  m_drain = 1'b0;
   bit  exp_done = 1'b0;
   int  m_owner = 0;
   int  m_rr = PORTS-1;
   int  ab_pulses = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [PORTS-1:0] req);
      for (int i = 1; i <= PORTS; i++) begin
         if (req[(last + i) % PORTS]) return (last + i) % PORTS;
      end
      return -1;
   endfunction

   // Source driver: stalls of more than TIMEOUT idle cycles mid-frame cause an abort
   task automatic drive_port(input int p);
      int len;
      bit ab;
      int ab_at;
      logic [DW-1:0] bd [5];
      logic          bk [5];
      logic          bu [5];
      int            gp [5];
      while (!stop_drv) begin
         repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
         len   = $urandom_range(1, 5);
         ab    = 1'b0;
         ab_at = len;
         for (int j = 0; j < len; j++) begin
            bd[j] = DW'($urandom);
            bk[j] = 1'($urandom);
            bu[j] = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 15))
               0:       gp[j] = TIMEOUT;
               1:       gp[j] = TIMEOUT + 1;
               2:       gp[j] = TIMEOUT + 1 + $urandom_range(0, 6);
               3, 4, 5: gp[j] = $urandom_range(1, TIMEOUT - 1);
               default: gp[j] = 0;
            endcase
            if (j > 0 && !ab && gp[j] > TIMEOUT) begin
               ab    = 1'b1;
               ab_at = j;
            end
         end
         for (int j = 0; j < ab_at; j++) exp_q[p].push_back({bu[j], (j == len - 1), bk[j], bd[j]});
         if (ab) exp_q[p].push_back({1'b1, 1'b1, 1'b1, 8'h00});
         ab_q[p].push_back(ab);
         for (int j = 0; j < len; j++) begin
            if (j > 0 && gp[j] > 0) begin
               p_valid[p] = 1'b0; p_last[p] = 1'b0; p_data[p] = '0;
               repeat (gp[j]) begin @(posedge clk); #1; end
            end
            p_valid[p] = 1'b1; p_data[p] = bd[j]; p_keep[p] = bk[j];
            p_user[p]  = bu[j]; p_last[p] = (j == len - 1);
            do @(negedge clk); while (!s_axis_tready[p]);
            @(posedge clk); #1;
         end
         p_valid[p] = 1'b0; p_last[p] = 1'b0; p_user[p] = 1'b0; p_data[p] = '0;
      end
      drv_done++;
   endtask

   // Sink readiness: mostly ready, with occasional 50-cycle backpressure bursts
   initial begin
      int burst = 0;
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (force_ready) m_axis_tready = 1'b1;
         else if (burst > 0) begin m_axis_tready = 1'b0; burst--; end
         else if ($urandom_range(0, 199) == 0) begin m_axis_tready = 1'b0; burst = 49; end
         else m_axis_tready = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor
   initial begin
      logic [10:0]      act;
      logic [10:0]      expv;
      logic [PORTS-1:0] req;
      logic [PORTS-1:0] exp_ta;
      bit               ab;
      bit               go_idle;
      bit               nxt_done;
      int               w;
      forever begin
         @(negedge clk);
         if (mon_en && rst) begin
            chk(!grant_valid && grant_index == 2'd3 && !m_axis_tvalid && s_axis_tready == 0 &&
                !frame_done && timeout_abort == 0 && m_axis_tdata == 0 && m_axis_tkeep == 0 &&
                !m_axis_tlast && !m_axis_tuser, "reset_state",
                {grant_valid, grant_index, m_axis_tvalid, s_axis_tready}, 64'h3 << 5);
            mb_busy = 0; m_drain = 0; exp_done = 0; m_rr = PORTS - 1; ab_pulses = 0;
         end else if (mon_en) begin
            go_idle  = 0;
            nxt_done = 0;
            chk(frame_done == exp_done, "frame_done", frame_done, exp_done);
            exp_ta = (mb_busy && !m_drain) ? PORTS'(1 << m_owner) : '0;
            if (timeout_abort != 0) begin
               chk(timeout_abort == exp_ta, "timeout_abort_port", timeout_abort, exp_ta);
               ab_pulses++;
            end
            if (mb_busy) chk(grant_valid && int'(grant_index) == m_owner, "grant",
                             {grant_valid, grant_index}, {1'b1, 2'(m_owner)});
            else chk(!grant_valid && !m_axis_tvalid, "idle_gap", {grant_valid, m_axis_tvalid}, 0);
            if (mb_busy && m_drain) begin
               chk(!m_axis_tvalid, "drain_quiet", m_axis_tvalid, 0);
               if (s_axis_tvalid[m_owner] && s_axis_tready[m_owner] && s_axis_tlast[m_owner])
                  go_idle = 1;
            end
            if (m_axis_tvalid && m_axis_tready) begin
               chk(mb_busy && !m_drain && exp_q[m_owner].size() > 0, "unexpected_beat",
                   {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, 0);
               if (mb_busy && !m_drain && exp_q[m_owner].size() > 0) begin
                  act  = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
                  expv = exp_q[m_owner].pop_front();
                  chk(act == expv, "beat", act, expv);
                  if (expv[9]) begin
                     ab = ab_q[m_owner].pop_front();
                     if (ab) begin
                        chk(ab_pulses == 1, "abort_pulse_count", ab_pulses, 1);
                        m_drain = 1;
                     end else begin
                        chk(ab_pulses == 0, "no_abort_pulse", ab_pulses, 0);
                        nxt_done = 1;
                        go_idle  = 1;
                     end
                  end
               end
            end
            if (go_idle) begin
               mb_busy = 0;
               m_drain = 0;
            end else if (!mb_busy) begin
               for (int i = 0; i < PORTS; i++) req[i] = p_valid[i];
               w = rr_pick(m_rr, req);
               if (w >= 0) begin
                  mb_busy   = 1;
                  m_owner   = w;
                  m_rr      = w;
                  ab_pulses = 0;
               end
            end
            exp_done = nxt_done;
         end
      end
   end

   initial begin
      bit got;
      for (int i = 0; i < PORTS; i++) begin
         p_data[i] = '0; p_keep[i] = 1'b0; p_valid[i] = 1'b0; p_last[i] = 1'b0; p_user[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
         fork
            automatic int pp = p;
            drive_port(pp);
         join_none
      end
      repeat (5000) @(posedge clk);
      stop_drv = 1'b1;
      for (int c = 0; c < 3000 && (drv_done < PORTS || mb_busy); c++) @(posedge clk);
      chk(drv_done == PORTS && !mb_busy, "traffic_completes", {drv_done, mb_busy}, PORTS << 1);
      for (int p = 0; p < PORTS; p++)
         chk(exp_q[p].size() == 0, "leftover_beats", exp_q[p].size(), 0);

      if (drv_done == PORTS) begin
         // Mid-frame reset on port 2, then simultaneous requests from 0 and 2
         @(posedge clk); #1;
         mon_en = 1'b0;
         force_ready = 1'b1;
         @(posedge clk); #1;
         p_valid[2] = 1'b1; p_data[2] = 8'h55; p_keep[2] = 1'b1; p_last[2] = 1'b0; p_user[2] = 1'b0;
         got = 0;
         for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant_valid && grant_index == 2'd2 && s_axis_tready[2]) got = 1;
         end
         chk(got, "rst_setup_grant", got, 1);
         @(posedge clk); #1;
         p_data[2] = 8'h56;
         #2 rst = 1'b1;
         #1;
         chk(!m_axis_tvalid && m_axis_tdata == 0 && m_axis_tkeep == 0 && !m_axis_tlast && !m_axis_tuser,
             "rst_m_axis_zero", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, 0);
         chk(s_axis_tready == 0, "rst_tready_zero", s_axis_tready, 0);
         chk(!grant_valid && grant_index == 2'd3, "rst_grant", {grant_valid, grant_index}, 3);
         chk(!frame_done && timeout_abort == 0, "rst_pulses", {frame_done, timeout_abort}, 0);
         p_valid[0] = 1'b1; p_data[0] = 8'h11; p_keep[0] = 1'b1; p_last[0] = 1'b1; p_user[0] = 1'b0;
         @(posedge clk); #1 rst = 1'b0;
         @(negedge clk);
         chk(!grant_valid, "post_rst_idle", grant_valid, 0);
         @(negedge clk);
         chk(grant_valid && grant_index == 2'd0, "post_rst_winner", {grant_valid, grant_index}, 4);
         chk(m_axis_tvalid && m_axis_tdata == 8'h11 && m_axis_tlast, "post_rst_beat",
             {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {2'b11, 8'h11});
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
`default_nettype wire
